// File: rtl/bin_to_bcd_seq_if.sv
// rtl/bin_to_bcd_seq_if.sv - handshake bundle for the sequential binary-to-BCD converter
//
// Purpose : groups the operand-in and result-out valid/ready channels plus busy.
// Signals :
//   in_valid  in_bin is valid this cycle            (master -> slave)
//   in_ready  converter can accept a new operand     (slave -> master)
//   in_bin    unsigned binary operand, WIDTH bits    (master -> slave)
//   out_valid out_bcd holds a finished result        (slave -> master)
//   out_ready downstream accepts the result          (master -> slave)
//   out_bcd   packed BCD, digit 0 in [3:0]           (slave -> master)
//   busy      converter is in SHIFT or DONE          (slave -> master)
interface bin_to_bcd_seq_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      in_bin;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   out_bcd;
    logic                  busy;

    modport master (
        output in_valid, in_bin, out_ready,
        input  in_ready, out_valid, out_bcd, busy
    );

    modport slave (
        input  in_valid, in_bin, out_ready,
        output in_ready, out_valid, out_bcd, busy
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential shift-add-3 binary-to-BCD converter, one shift per clock
//
// Purpose : converts a WIDTH-bit unsigned operand into DIGITS packed BCD digits
//           using double-dabble, one shift per clock, with valid/ready on both sides.
// Ports   :
//   clk    single clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    bin_to_bcd_seq_if.slave (in_valid/in_ready/in_bin, out_valid/out_ready/out_bcd, busy)
module bin_to_bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bin_to_bcd_seq_if.slave      bus
);
    localparam int     CNT_W     = $clog2(WIDTH + 1);
    localparam int     BCD_W     = 4 * DIGITS;
    localparam longint MAX_BIN   = (longint'(1) << WIDTH) - 1;
    localparam longint DEC_RANGE = longint'(10) ** DIGITS;

    // The top digit can only stay in 0..9 if DIGITS decimal places cover the binary range.
    generate
        if (DEC_RANGE <= MAX_BIN) begin : g_bad_digits
            $error("bin_to_bcd_seq: DIGITS too small for WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [WIDTH-1:0]   r_bin;
    logic [BCD_W-1:0]   r_bcd;
    logic [CNT_W-1:0]   r_cnt;
    logic [BCD_W-1:0]   w_bcd_adj;
    logic               w_last_shift;

    // Add-3 correction on every digit in parallel, applied before the shift so
    // that a digit of 5..9 carries correctly into the next digit after doubling.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5) begin
                w_bcd_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
            end
        end
    end

    assign w_last_shift = (r_cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (bus.in_valid)  w_next_state = S_SHIFT;
            S_SHIFT: if (w_last_shift)  w_next_state = S_DONE;
            S_DONE:  if (bus.out_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bin <= '0;
            r_bcd <= '0;
            r_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_bin <= bus.in_bin;
                        r_bcd <= '0;
                        r_cnt <= '0;
                    end
                end
                S_SHIFT: begin
                    // The top bit of the adjusted accumulator is always zero here,
                    // so dropping it during the shift loses nothing.
                    {r_bcd, r_bin} <= {w_bcd_adj[BCD_W-2:0], r_bin, 1'b0};
                    r_cnt          <= r_cnt + 1'b1;
                end
                default: begin
                    // DONE holds the result stable until the downstream takes it.
                end
            endcase
        end
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        bus.out_bcd   = r_bcd;
        case (r_state)
            S_IDLE:  bus.in_ready = 1'b1;
            S_SHIFT: bus.busy     = 1'b1;
            S_DONE: begin
                bus.out_valid = 1'b1;
                bus.busy      = 1'b1;
            end
            default: bus.in_ready = 1'b0;
        endcase
    end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - self-checking bench for bin_to_bcd_seq
module tb_bin_to_bcd_seq;
    localparam int WIDTH  = 8;
    localparam int DIGITS = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bin_to_bcd_seq_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

    bin_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0]  bin;
        logic [11:0] bcd;
    } vec_t;

    int checks = 0;
    int errors = 0;

    int          cyc;
    int          last_acc;
    int          n_acc;
    int          n_res;
    bit          timing_on;
    bit          held;
    logic [11:0] held_bcd;
    logic [11:0] exp_q[$];
    int          acc_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain decimal digit extraction.
    function automatic logic [11:0] bcd_of(input int v);
        int          t;
        logic [11:0] r;
        t = v;
        r = '0;
        for (int d = 0; d < DIGITS; d++) begin
            r[4*d +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Called at a falling edge after the inputs for the coming rising edge are set.
    task automatic observe(output bit accepted);
        int a;
        accepted = 1'b0;
        if (held) begin
            check("hold_valid", 32'(bus.out_valid), 32'd1);
            check("hold_bcd", 32'(bus.out_bcd), 32'(held_bcd));
        end
        if (bus.in_valid && bus.in_ready) begin
            accepted = 1'b1;
            exp_q.push_back(bcd_of(int'(bus.in_bin)));
            acc_q.push_back(cyc);
            if (timing_on && last_acc >= 0) check("accept_gap", 32'(cyc - last_acc), 32'd10);
            last_acc = cyc;
            n_acc++;
        end
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_result: got %0h expected none", bus.out_bcd);
            end else begin
                check("stream_result", 32'(bus.out_bcd), 32'(exp_q.pop_front()));
                a = acc_q.pop_front();
                if (timing_on) check("stream_latency", 32'(cyc - a), 32'd9);
            end
            n_res++;
        end
        held     = bus.out_valid && !bus.out_ready;
        held_bcd = bus.out_bcd;
    endtask

    // Caller is at a falling edge. lat counts falling edges from the one where the
    // operand is presented to the first one that shows out_valid.
    task automatic convert(input logic [7:0] v, output logic [11:0] res, output int lat);
        int w;
        w = 0;
        bus.out_ready = 1'b1;
        while (!bus.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        bus.in_valid = 1'b1;
        bus.in_bin   = v;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        res = bus.out_bcd;
    endtask

    vec_t        vecs[8];
    logic [11:0] res;
    int          lat;
    int          w;
    int          next_op;
    bit          acc;

    initial begin
        vecs[0] = '{8'd0,   12'h000};
        vecs[1] = '{8'd255, 12'h255};
        vecs[2] = '{8'd99,  12'h099};
        vecs[3] = '{8'd100, 12'h100};
        vecs[4] = '{8'd9,   12'h009};
        vecs[5] = '{8'd1,   12'h001};
        vecs[6] = '{8'd10,  12'h010};
        vecs[7] = '{8'd199, 12'h199};

        bus.in_valid  = 1'b0;
        bus.in_bin    = '0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_out_bcd", 32'(bus.out_bcd), 32'h000);

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            convert(vecs[i].bin, res, lat);
            check($sformatf("table_bcd[%0d]", vecs[i].bin), 32'(res), 32'(vecs[i].bcd));
            check($sformatf("table_latency[%0d]", vecs[i].bin), 32'(lat), 32'd9);
        end
        @(negedge clk);

        // Backpressure in DONE with 137.
        bus.out_ready = 1'b0;
        w = 0;
        while (!bus.in_ready && w < 50) begin @(negedge clk); w++; end
        bus.in_valid = 1'b1;
        bus.in_bin   = 8'd137;
        @(negedge clk);
        bus.in_valid = 1'b0;
        w = 0;
        while (!bus.out_valid && w < 50) begin @(negedge clk); w++; end
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_out_bcd", 32'(bus.out_bcd), 32'h137);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_busy", 32'(bus.busy), 32'd1);
            bus.in_valid = 1'(i % 2 == 0);
            bus.in_bin   = 8'd55;
            @(negedge clk);
        end
        check("bp_final_bcd", 32'(bus.out_bcd), 32'h137);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 32'(bus.out_valid), 32'd0);
        check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        check("bp_no_ghost_busy", 32'(bus.busy), 32'd0);

        // Reset while in SHIFT with cnt at 4.
        bus.in_valid = 1'b1;
        bus.in_bin   = 8'd200;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_shift_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_out_bcd", 32'(bus.out_bcd), 32'h000);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        convert(8'd42, res, lat);
        check("after_rst_bcd", 32'(res), 32'h042);
        check("after_rst_latency", 32'(lat), 32'd9);

        // Exhaustive sweep with in_valid held high and out_ready high.
        timing_on = 1'b1;
        held      = 1'b0;
        last_acc  = -1;
        n_acc     = 0;
        n_res     = 0;
        cyc       = 0;
        next_op   = 0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4000 && n_res < 256; i++) begin
            @(negedge clk);
            cyc++;
            bus.in_valid = (next_op < 256);
            bus.in_bin   = 8'(next_op);
            observe(acc);
            if (acc) next_op++;
        end
        bus.in_valid = 1'b0;
        check("sweep_accepts", 32'(n_acc), 32'd256);
        check("sweep_results", 32'(n_res), 32'd256);
        check("sweep_queue_empty", 32'(exp_q.size()), 32'd0);

        // Random operands, random in_valid and random backpressure.
        timing_on = 1'b0;
        held      = 1'b0;
        n_acc     = 0;
        n_res     = 0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            cyc++;
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_bin    = 8'($urandom);
            bus.out_ready = 1'($urandom_range(0, 1));
            observe(acc);
        end
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
            @(negedge clk);
            cyc++;
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
            observe(acc);
        end
        check("random_drain", 32'(exp_q.size()), 32'd0);
        check("random_count", 32'(n_res), 32'(n_acc));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
